// File: rtl/edge_detector.sv
// edge_detector: turns a level input into a registered strobe of PULSE_LEN
// cycles on each qualifying transition. Moore FSM with an optional input
// synchronizer chain and a selectable edge polarity.
module edge_detector #(
   parameter int SYNC_STAGES = 0,  // 0 = sample signal directly
   parameter int EDGE_MODE   = 0,  // 0 = rising, 1 = falling, 2 = both
   parameter int PULSE_LEN   = 1   // strobe width in cycles, 1..255
) (
   input  logic clk,
   input  logic reset,     // asynchronous, active low
   input  logic signal,
   output logic outedge
);

   // LOW and HIGH also remember the previous sampled level of s, so no
   // separate prev register is needed.
   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_LOW   = 2'd1,
      ST_HIGH  = 2'd2,
      ST_PULSE = 2'd3
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);
   localparam logic       RISE_EN  = (EDGE_MODE == 0) || (EDGE_MODE == 2);
   localparam logic       FALL_EN  = (EDGE_MODE == 1) || (EDGE_MODE == 2);

   logic       s_s;
   state_t     state_r;
   state_t     state_next_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_next_s;
   logic       outedge_r;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_s = signal;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_r;

         // Shift the raw input through the synchronizer chain.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync_r <= '0;
            end else begin
               sync_r[0] <= signal;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_r[i] <= sync_r[i-1];
               end
            end
         end

         assign s_s = sync_r[SYNC_STAGES-1];
      end
   endgenerate

   // Next-state and pulse-counter logic; edges seen while in PULSE are
   // dropped and the exit state simply follows the current level.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_INIT: begin
            if (s_s) begin
               state_next_s = ST_HIGH;
            end else begin
               state_next_s = ST_LOW;
            end
         end
         ST_LOW: begin
            if (s_s) begin
               if (RISE_EN) begin
                  state_next_s = ST_PULSE;
                  cnt_next_s   = CNT_LOAD;
               end else begin
                  state_next_s = ST_HIGH;
               end
            end else begin
               state_next_s = ST_LOW;
            end
         end
         ST_HIGH: begin
            if (!s_s) begin
               if (FALL_EN) begin
                  state_next_s = ST_PULSE;
                  cnt_next_s   = CNT_LOAD;
               end else begin
                  state_next_s = ST_LOW;
               end
            end else begin
               state_next_s = ST_HIGH;
            end
         end
         ST_PULSE: begin
            if (cnt_r == 8'd0) begin
               if (s_s) begin
                  state_next_s = ST_HIGH;
               end else begin
                  state_next_s = ST_LOW;
               end
            end else begin
               cnt_next_s = cnt_r - 8'd1;
            end
         end
         default: begin
            state_next_s = ST_INIT;
            cnt_next_s   = 8'd0;
         end
      endcase
   end

   // State, counter and output flops; the output is its own flop so the
   // strobe never sees decode glitches from the state bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_INIT;
         cnt_r     <= 8'd0;
         outedge_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         cnt_r     <= cnt_next_s;
         outedge_r <= (state_next_s == ST_PULSE);
      end
   end

   assign outedge = outedge_r;

endmodule

// File: tb/tb_edge_detector.sv
// tb_edge_detector: drives four differently-parameterised edge detectors
// from one shared input and compares each against a behavioural model.
module tb_edge_detector;

   localparam int N = 4;
   localparam int SYNC_P [N] = '{0, 0, 0, 2};
   localparam int MODE_P [N] = '{0, 1, 2, 2};
   localparam int LEN_P  [N] = '{1, 1, 4, 3};

   logic         clk = 1'b0;
   logic         reset;
   logic         signal;
   logic [N-1:0] outs;

   int tests_run = 0;
   int failures  = 0;

   // Reference model state: raw samples since reset, per-instance level,
   // remaining pulse edges and expected output.
   bit           hist[$];
   bit           lvl_m  [N];
   bit           init_m [N];
   int           left_m [N];
   logic [N-1:0] exp_out = '0;
   bit           s_m;
   bit           qual_m;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         edge_detector #(
            .SYNC_STAGES(SYNC_P[g]),
            .EDGE_MODE  (MODE_P[g]),
            .PULSE_LEN  (LEN_P[g])
         ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .signal (signal),
            .outedge(outs[g])
         );
      end
   endgenerate

   // Behavioural model: s is the input as seen SYNC edges ago (zero before
   // reset release); a qualifying change of level starts LEN high cycles,
   // after which the remembered level is resynchronised to s.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist.delete();
         for (int i = 0; i < N; i++) begin
            init_m[i] = 1'b0;
            left_m[i] = 0;
            lvl_m[i]  = 1'b0;
         end
         exp_out = '0;
      end else begin
         hist.push_back(signal);
         for (int i = 0; i < N; i++) begin
            s_m = (hist.size() > SYNC_P[i]) ? hist[hist.size() - 1 - SYNC_P[i]] : 1'b0;
            if (!init_m[i]) begin
               init_m[i]  = 1'b1;
               lvl_m[i]   = s_m;
               exp_out[i] = 1'b0;
            end else if (left_m[i] > 0) begin
               left_m[i] = left_m[i] - 1;
               if (left_m[i] == 0) begin
                  exp_out[i] = 1'b0;
                  lvl_m[i]   = s_m;
               end else begin
                  exp_out[i] = 1'b1;
               end
            end else if (s_m != lvl_m[i]) begin
               qual_m   = s_m ? (MODE_P[i] != 1) : (MODE_P[i] != 0);
               lvl_m[i] = s_m;
               if (qual_m) begin
                  left_m[i]  = LEN_P[i];
                  exp_out[i] = 1'b1;
               end else begin
                  exp_out[i] = 1'b0;
               end
            end else begin
               exp_out[i] = 1'b0;
            end
         end
      end
   end

   task automatic test_reset();
      reset  = 1'b0;
      signal = 1'b0;
      repeat (5) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== 1'b0) begin
               failures++;
               $display("FAIL reset_hold u%0d @%0t: outedge=%b expected 0", i, $time, outs[i]);
            end
         end
      end
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL reset_idle u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
   endtask

   task automatic test_rise();
      int cnt0 = 0;
      signal = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (outs[0]) cnt0++;
         if (c == 0) begin
            tests_run++;
            if (outs[0] !== 1'b1) begin
               failures++;
               $display("FAIL rise_latency u0 @%0t: outedge=%b expected 1", $time, outs[0]);
            end
         end
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL rise u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      tests_run++;
      if (cnt0 !== 1) begin
         failures++;
         $display("FAIL rise_width u0: high cycles=%0d expected 1", cnt0);
      end
   endtask

   task automatic test_fall();
      int cnt0 = 0;
      int cnt1 = 0;
      signal = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (outs[0]) cnt0++;
         if (outs[1]) cnt1++;
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL fall u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      tests_run++;
      if (cnt0 !== 0) begin
         failures++;
         $display("FAIL fall_rise_mode u0: high cycles=%0d expected 0", cnt0);
      end
      tests_run++;
      if (cnt1 !== 1) begin
         failures++;
         $display("FAIL fall_fall_mode u1: high cycles=%0d expected 1", cnt1);
      end
   endtask

   task automatic test_init_high();
      int cnt_init = 0;
      int cnt_rise = 0;
      reset  = 1'b0;
      signal = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (c == 5) signal = 1'b0;
         if (c == 8) signal = 1'b1;
         @(negedge clk);
         if (c < 5 && outs[0]) cnt_init++;
         if (c >= 5 && outs[0]) cnt_rise++;
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL init_high u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      tests_run++;
      if (cnt_init !== 0) begin
         failures++;
         $display("FAIL init_no_pulse u0: high cycles=%0d expected 0", cnt_init);
      end
      tests_run++;
      if (cnt_rise !== 1) begin
         failures++;
         $display("FAIL init_new_rise u0: high cycles=%0d expected 1", cnt_rise);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int cnt2 = 0;
      signal = 1'b0;
      repeat (8) @(negedge clk);
      signal = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (outs[2] !== 1'b1) begin
         failures++;
         $display("FAIL mid_pulse_active u2 @%0t: outedge=%b expected 1", $time, outs[2]);
      end
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (outs[2] !== 1'b0) begin
         failures++;
         $display("FAIL mid_pulse_async u2 @%0t: outedge=%b expected 0", $time, outs[2]);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (outs[2]) cnt2++;
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL mid_pulse_after u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      tests_run++;
      if (cnt2 !== 0) begin
         failures++;
         $display("FAIL mid_pulse_restart u2: high cycles=%0d expected 0", cnt2);
      end
   endtask

   task automatic test_sync_len();
      int first0 = -1;
      int first3 = -1;
      int cnt3   = 0;
      signal = 1'b0;
      repeat (10) @(negedge clk);
      signal = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (outs[0] && first0 < 0) first0 = c;
         if (outs[3] && first3 < 0) first3 = c;
         if (outs[3]) cnt3++;
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL sync_len u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      tests_run++;
      if (cnt3 !== 3) begin
         failures++;
         $display("FAIL sync_len_width u3: high cycles=%0d expected 3", cnt3);
      end
      tests_run++;
      if ((first3 - first0) !== 2 || first0 < 0) begin
         failures++;
         $display("FAIL sync_len_delay u3: start offset=%0d expected 2 (u0 start %0d)", first3 - first0, first0);
      end
   endtask

   task automatic test_back_to_back();
      int cnt0 = 0;
      signal = 1'b0;
      repeat (10) @(negedge clk);
      for (int c = 0; c < 14; c++) begin
         signal = (c < 12) ? ~c[0] : 1'b0;
         @(negedge clk);
         if (outs[0]) cnt0++;
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL back_to_back u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      tests_run++;
      if (cnt0 !== 6) begin
         failures++;
         $display("FAIL back_to_back_count u0: pulses=%0d expected 6", cnt0);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) signal = ~signal;
         if ($urandom_range(0, 99) == 0) reset = 1'b0;
         else reset = 1'b1;
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            tests_run++;
            if (outs[i] !== exp_out[i]) begin
               failures++;
               $display("FAIL random u%0d @%0t: outedge=%b expected %b", i, $time, outs[i], exp_out[i]);
            end
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      reset  = 1'b0;
      signal = 1'b0;
      test_reset();
      test_rise();
      test_fall();
      test_init_high();
      test_reset_mid_pulse();
      test_sync_len();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
